sha512_padder: RTL and testbench
================================

# sha512_padder

Front end of the SHA-512 accelerator. Receives message data as a stream of 512-bit cache lines from the CCI-P read path and emits fully padded 1024-bit SHA-512 message blocks to the hash core. Applies FIPS 180-4 padding: the 0x80 marker, zero fill, and a 128-bit big-endian bit-length field. Generates the extra trailing block when the padding does not fit.

## Interface
- No parameters.
- clk  input  1  clock; all logic on the rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  one-cycle pulse that begins a message; honoured only when busy=0
- msg_len  input  32  message length in bytes, sampled on start
- line  input  512  message data; byte i = line[8*i +: 8]; earliest message byte is byte 0
- line_valid  input  1  line holds valid data
- line_ready  output  1  padder accepts line this cycle
- block  output  1024  padded block; byte j = block[8*j +: 8]
- block_valid  output  1  block is valid
- block_ready  input  1  core accepts block
- block_last  output  1  qualifies block_valid; final block of the message
- busy  output  1  message in progress (start accepted, final block not yet handshaken)

## Operation
- Define L = msg_len, lines = ceil(L/64), blocks = floor((L+16)/128)+1.
- States:
  - IDLE: start moves to FILL_LO, or to PAD_ONLY when L=0.
  - FILL_LO: accepts the line for block bytes 0..63.
  - FILL_HI: accepts the line for block bytes 64..127.
  - PAD_ONLY: no input is accepted. The block is built from padding alone.
  - EMIT: holds the block until handshake.
- Byte counter tracks message bytes consumed (33 bits internally). When the counter reaches L, the current block is finished immediately with padding. No further lines are requested for that block.
- Padding within the block that holds message byte L-1:
  - Bytes at block offset >= L mod 128 are overwritten: byte (L mod 128) = 0x80, the rest = 0x00.
  - Line bytes past L in the final line are ignored.
- Length field: bytes 112..127 of the final block hold L*8 as a 128-bit big-endian value. Byte 112 is the MSB, byte 127 is the LSB, and bits above 34 are zero.
- If L mod 128 >= 112 (and L > 0), the data block carries the 0x80 with no length. One extra PAD_ONLY block follows, all zero except the length field.
- If L is a nonzero multiple of 128, the final data block carries no padding. The extra block has byte 0 = 0x80 plus the length field.
- Transitions out of EMIT on handshake:
  - To FILL_LO if message bytes remain.
  - To PAD_ONLY if only the extra block remains.
  - To IDLE after the block_last handshake.
- start while busy=1 is ignored. msg_len is not resampled.

## Timing
- Reset values: line_ready=0, block_valid=0, block_last=0, busy=0, block=0; state IDLE, counter 0. Reset asserted mid-message aborts it with no block emitted. The first start after reset release is honoured.
- busy rises the cycle after start and falls the cycle after the block_last handshake. start is accepted in that following cycle.
- line_ready=1 only in FILL_LO/FILL_HI. A handshake is line_valid & line_ready, with at most one line per cycle.
- Two back-to-back lines take 2 cycles. block_valid rises the cycle after the handshake of the last contributing line.
- PAD_ONLY takes 1 cycle: block_valid rises 2 cycles after start (L=0) or after the previous block handshake.
- block, block_valid and block_last stay stable until block_valid & block_ready. line_ready=0 throughout EMIT.
- Back-to-back blocks: after a handshake, line_ready=1 on the next cycle, so there is a minimum 3-cycle period per block when data lines are needed.
- line_valid without a started message is not consumed.

## Test plan
- "abc", L=3: line bytes 0..2 = 61 62 63 -> one block with bytes 0..2 = 61 62 63, byte 3 = 0x80, bytes 4..126 = 0, byte 127 = 0x18; block_last=1; exactly one line accepted.
- L=0: start only -> no line accepted; one block with byte 0 = 0x80, all other bytes 0, block_last=1, block_valid 2 cycles after start.
- L=112: two lines -> block 1 has byte 112 = 0x80, block_last=0. Block 2 is all zero except byte 126 = 0x03, byte 127 = 0x80, with block_last=1.
- L=128 then L=200 back-to-back: first message gives 2 blocks, the second with byte 0 = 0x80 and bytes 126..127 = 04 00. Second message gives 2 blocks: 0x80 at byte 72 of block 2, length 0x0640 at bytes 126..127, 4 lines accepted.
- Backpressure: block_ready held low 10 cycles, line_valid high throughout -> block stable, line_ready=0, no extra line consumed. Also: start during busy ignored.
- Reset asserted mid-FILL_HI -> all outputs 0 asynchronously; a subsequent L=3 message produces the correct single block.

Source files
------------

// File: rtl/sha512_padder.sv
// rtl/sha512_padder.sv - FIPS 180-4 padder: 512-bit message lines in, padded 1024-bit SHA-512 blocks out
module sha512_padder (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [31:0]   msg_len,
  input  logic [511:0]  line,
  input  logic          line_valid,
  output logic          line_ready,
  output logic [1023:0] block,
  output logic          block_valid,
  input  logic          block_ready,
  output logic          block_last,
  output logic          busy
);

  typedef enum logic [2:0] {IDLE, FILL_LO, FILL_HI, PAD_ONLY, EMIT} state_t;

  state_t        state_q, state_d;
  logic [31:0]   len_q, len_d;
  logic [32:0]   cnt_q, cnt_d;
  logic [1023:0] blk_q, blk_d;
  logic          last_q, last_d;
  logic          extra_q, extra_d;
  logic          marker_q, marker_d;

  logic [32:0]   rem;
  logic          take_all;
  logic [6:0]    take;
  logic [6:0]    r;
  logic [127:0]  len_field;
  logic [1023:0] len_blk;
  logic [511:0]  line_masked;
  logic [1023:0] merged;
  logic [1023:0] padded;
  logic          tail_extra;

  // Datapath: mask the incoming line to the bytes still owed, merge it into
  // the proper half, and pre-compute the padded form for the final line.
  always_comb begin
    rem      = {1'b0, len_q} - cnt_q;
    take_all = (rem <= 33'd64);
    take     = take_all ? rem[6:0] : 7'd64;
    r        = len_q[6:0];
    len_field = {93'd0, len_q, 3'd0};
    len_blk   = '0;
    for (int k = 0; k < 16; k++)
      len_blk[8*(112+k) +: 8] = len_field[8*(15-k) +: 8];
    for (int i = 0; i < 64; i++)
      line_masked[8*i +: 8] = (7'(i) < take) ? line[8*i +: 8] : 8'h00;
    merged = (state_q == FILL_HI) ? {line_masked, blk_q[511:0]}
                                  : {blk_q[1023:512], line_masked};
    padded = merged;
    if (r != 7'd0) begin
      padded[{r, 3'b000} +: 8] = 8'h80;
      if (r < 7'd112)
        padded = padded | len_blk;
    end
    // Full final block or no room for the length: one more block follows.
    tail_extra = (r == 7'd0) || (r >= 7'd112);
  end

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    blk_d    = blk_q;
    last_d   = last_q;
    extra_d  = extra_q;
    marker_d = marker_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          len_d    = msg_len;
          cnt_d    = '0;
          blk_d    = '0;
          last_d   = 1'b0;
          extra_d  = 1'b0;
          marker_d = (msg_len == 32'd0);
          state_d  = (msg_len == 32'd0) ? PAD_ONLY : FILL_LO;
        end
      end
      FILL_LO, FILL_HI: begin
        if (line_valid) begin
          cnt_d = cnt_q + {26'd0, take};
          if (take_all) begin
            blk_d    = padded;
            extra_d  = tail_extra;
            marker_d = (r == 7'd0);
            last_d   = !tail_extra;
            state_d  = EMIT;
          end else begin
            blk_d   = merged;
            state_d = (state_q == FILL_HI) ? EMIT : FILL_HI;
          end
        end
      end
      PAD_ONLY: begin
        blk_d = len_blk;
        if (marker_q)
          blk_d[7:0] = 8'h80;
        last_d  = 1'b1;
        extra_d = 1'b0;
        state_d = EMIT;
      end
      EMIT: begin
        if (block_ready) begin
          blk_d = '0;
          if (last_q)
            state_d = IDLE;
          else if (extra_q)
            state_d = PAD_ONLY;
          else
            state_d = FILL_LO;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      len_q    <= '0;
      cnt_q    <= '0;
      blk_q    <= '0;
      last_q   <= 1'b0;
      extra_q  <= 1'b0;
      marker_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      blk_q    <= blk_d;
      last_q   <= last_d;
      extra_q  <= extra_d;
      marker_q <= marker_d;
    end
  end

  assign line_ready  = (state_q == FILL_LO) || (state_q == FILL_HI);
  assign block_valid = (state_q == EMIT);
  assign block_last  = (state_q == EMIT) && last_q;
  assign busy        = (state_q != IDLE);
  assign block       = blk_q;

endmodule

// File: tb/tb_sha512_padder.sv
// tb/tb_sha512_padder.sv - scoreboard bench for sha512_padder against a byte-queue padding model
module tb_sha512_padder;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [31:0]   msg_len;
  logic [511:0]  line;
  logic          line_valid;
  logic          line_ready;
  logic [1023:0] block;
  logic          block_valid;
  logic          block_ready;
  logic          block_last;
  logic          busy;

  sha512_padder dut (
    .clk(clk), .reset(reset), .start(start), .msg_len(msg_len),
    .line(line), .line_valid(line_valid), .line_ready(line_ready),
    .block(block), .block_valid(block_valid), .block_ready(block_ready),
    .block_last(block_last), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [1023:0] exp_blk_q[$];
  bit            exp_last_q[$];
  logic [511:0]  line_q[$];
  int            lines_taken = 0;
  int            exp_lines   = 0;
  bit            check_lines = 0;
  bit            force_valid = 0;
  bit            ready_hold  = 0;
  logic [1023:0] last_seen   = '0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_blk(input string nm, input logic [1023:0] act, input logic [1023:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      for (int j = 0; j < 128; j++) begin
        if (act[8*j +: 8] !== exp[8*j +: 8]) begin
          $display("FAIL %s: byte %0d got %02h expected %02h", nm, j, act[8*j +: 8], exp[8*j +: 8]);
          break;
        end
      end
    end
  endtask

  // Input drivers: lines from the outstanding queue, random gaps and ready.
  initial begin
    line_valid  = 1'b0;
    line        = '0;
    block_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      line_valid  = force_valid || (line_q.size() > 0 && $urandom_range(0, 3) != 0);
      line        = (line_q.size() > 0) ? line_q[0] : {16{$urandom}};
      block_ready = !ready_hold && ($urandom_range(0, 2) != 0);
    end
  end

  // Monitor: consumes line handshakes and checks every block handshake.
  initial begin
    bit            stall_prev = 0;
    logic [1023:0] prev_blk   = '0;
    logic [1023:0] e;
    bit            el;
    forever begin
      @(negedge clk);
      if (line_valid && line_ready) begin
        chk("line_outstanding", line_q.size() > 0, 1);
        if (line_q.size() > 0) begin
          void'(line_q.pop_front());
          lines_taken++;
        end
      end
      if (stall_prev && block_valid)
        chk_blk("block_stable", block, prev_blk);
      if (block_valid && block_ready) begin
        chk("block_expected", exp_blk_q.size() > 0, 1);
        if (exp_blk_q.size() > 0) begin
          e  = exp_blk_q.pop_front();
          el = exp_last_q.pop_front();
          chk_blk("block_data", block, e);
          chk("block_last", block_last, el);
          last_seen = block;
        end
      end
      stall_prev = block_valid && !block_ready;
      prev_blk   = block;
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((busy || exp_blk_q.size() != 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout: busy=%0d pending_blocks=%0d", busy, exp_blk_q.size());
      exp_blk_q.delete();
      exp_last_q.delete();
      line_q.delete();
    end
    if (check_lines) begin
      chk("lines_accepted", lines_taken, exp_lines);
      check_lines = 0;
    end
  endtask

  // Model: append 0x80, zero-fill to 112 mod 128, append 16-byte length, slice.
  task automatic send_msg(input int L, input bit abc);
    byte unsigned  mb[$];
    byte unsigned  p[$];
    logic [511:0]  ln;
    logic [1023:0] b;
    logic [63:0]   lb;
    int            nb;
    wait_idle();
    for (int i = 0; i < L; i++)
      mb.push_back(abc ? 8'(8'h61 + i) : 8'($urandom));
    for (int i = 0; i < (L + 63) / 64; i++) begin
      for (int j = 0; j < 64; j++)
        ln[8*j +: 8] = (64*i + j < L) ? mb[64*i + j] : 8'($urandom);
      line_q.push_back(ln);
    end
    p = mb;
    p.push_back(8'h80);
    while (p.size() % 128 != 112)
      p.push_back(8'h00);
    lb = 64'(L) * 64'd8;
    for (int k = 15; k >= 0; k--)
      p.push_back((k < 8) ? 8'(lb >> (8*k)) : 8'h00);
    nb = p.size() / 128;
    for (int bi = 0; bi < nb; bi++) begin
      for (int j = 0; j < 128; j++)
        b[8*j +: 8] = p[128*bi + j];
      exp_blk_q.push_back(b);
      exp_last_q.push_back(bi == nb - 1);
    end
    exp_lines   = (L + 63) / 64;
    lines_taken = 0;
    check_lines = 1;
    @(posedge clk); #1;
    start   = 1'b1;
    msg_len = 32'(L);
    @(posedge clk); #1;
    start   = 1'b0;
    msg_len = $urandom;
    @(negedge clk);
    chk("busy_after_start", busy, 1);
    if (L == 0) begin
      chk("l0_valid_early", block_valid, 0);
      @(negedge clk);
      chk("l0_valid_2cyc", block_valid, 1);
    end
  endtask

  initial begin
    int n;
    int L;
    int bl[15] = '{1, 63, 64, 65, 111, 112, 113, 127, 128, 129, 239, 240, 255, 256, 257};
    logic [1023:0] snap;
    reset   = 1'b0;
    start   = 1'b0;
    msg_len = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_line_ready", line_ready, 0);
    chk("rst_block_valid", block_valid, 0);
    chk("rst_block_last", block_last, 0);
    chk("rst_busy", busy, 0);
    chk_blk("rst_block", block, '0);
    #2 reset = 1'b1;

    send_msg(3, 1);
    wait_idle();
    chk("abc_byte3", last_seen[8*3 +: 8], 8'h80);
    chk("abc_byte127", last_seen[8*127 +: 8], 8'h18);

    send_msg(0, 0);
    wait_idle();
    chk("l0_byte0", last_seen[7:0], 8'h80);

    send_msg(112, 0);
    wait_idle();
    chk("l112_byte126", last_seen[8*126 +: 8], 8'h03);
    chk("l112_byte127", last_seen[8*127 +: 8], 8'h80);

    send_msg(128, 0);
    send_msg(200, 0);
    wait_idle();
    chk("l200_byte72", last_seen[8*72 +: 8], 8'h80);

    // Backpressure with line_valid forced high and a start while busy.
    ready_hold  = 1;
    force_valid = 1;
    send_msg(3, 0);
    n = 0;
    while (!block_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid_seen", block_valid, 1);
    snap = block;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk_blk("bp_hold", block, snap);
      chk("bp_line_ready", line_ready, 0);
      chk("bp_valid", block_valid, 1);
      start = (i == 3);
      if (i == 3)
        msg_len = 32'd5;
    end
    start      = 1'b0;
    ready_hold = 0;
    wait_idle();
    force_valid = 0;

    // Reset asserted while waiting in FILL_HI.
    line_q.push_back({16{$urandom}});
    lines_taken = 0;
    @(posedge clk); #1;
    start   = 1'b1;
    msg_len = 32'd300;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (lines_taken < 1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("mid_first_line", lines_taken, 1);
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("mid_rst_line_ready", line_ready, 0);
    chk("mid_rst_block_valid", block_valid, 0);
    chk("mid_rst_block_last", block_last, 0);
    chk("mid_rst_busy", busy, 0);
    chk_blk("mid_rst_block", block, '0);
    @(posedge clk);
    #4 reset = 1'b1;
    send_msg(3, 1);
    wait_idle();
    chk("post_rst_byte127", last_seen[8*127 +: 8], 8'h18);

    for (int i = 0; i < 40; i++) begin
      L = (i < 15) ? bl[i] : int'($urandom_range(0, 700));
      send_msg(L, 0);
    end
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
